// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file dump reader.
// A streamed word carries its register address, contents and an end-of-dump flag.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;
    // Remaining-word counter must hold NREGS itself, hence one extra bit.
    localparam int CNT_W  = ADDR_W + 1;
    localparam int WORD_W = ADDR_W + DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rf_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } rf_word_t;

endpackage

// File: rtl/rf_out_buf.sv
// Two-entry output FIFO of packed rf_word_t; accepts up to two writes per cycle.
// The head entry sits in a flop, so everything presented downstream is registered.
module rf_out_buf
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push0,
    input  logic [WORD_W-1:0] wr0,
    input  logic              push1,
    input  logic [WORD_W-1:0] wr1,
    input  logic              ready,
    output logic              valid,
    output logic [WORD_W-1:0] head,
    output logic [1:0]        count
);

    logic [WORD_W-1:0] slot_q [2];
    logic [WORD_W-1:0] slot_d [2];
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              pop;

    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        pop     = ready && (count_q != 2'd0);
        // Pop shifts first so pushes land behind whatever survives.
        if (pop) begin
            slot_d[0] = slot_q[1];
            count_d   = count_q - 2'd1;
        end
        if (push0 && (count_d < 2'd2)) begin
            slot_d[count_d[0]] = wr0;
            count_d            = count_d + 2'd1;
        end
        if (push1 && (count_d < 2'd2)) begin
            slot_d[count_d[0]] = wr1;
            count_d            = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            count_q   <= 2'd0;
        end else begin
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            count_q   <= count_d;
        end
    end

    assign valid = (count_q != 2'd0);
    assign head  = slot_q[0];
    assign count = count_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a wrapping register range two registers per fetch and streams {addr, data}
// over valid/ready, keeping a running XOR checksum of every accepted word.
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    // Stream handshake: a word transfers on a rising edge where out_valid && out_ready;
    // once out_valid rises, it and the word fields stay fixed until that transfer.

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] ra1_q, ra1_d;
    logic [ADDR_W-1:0] ra2_q, ra2_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;

    logic              push0, push1, pop;
    rf_word_t          wr0, wr1, head;
    logic [WORD_W-1:0] head_bits;
    logic              buf_valid;
    logic [1:0]        buf_count;
    logic [ADDR_W-1:0] span;

    rf_out_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push0 (push0),
        .wr0   (wr0),
        .push1 (push1),
        .wr1   (wr1),
        .ready (out_ready),
        .valid (buf_valid),
        .head  (head_bits),
        .count (buf_count)
    );

    assign head = rf_word_t'(head_bits);

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rem_d      = rem_q;
        checksum_d = checksum_q;
        push0      = 1'b0;
        push1      = 1'b0;
        pop        = buf_valid && out_ready;
        span       = last_addr - first_addr;
        wr0        = '{addr: cur_q, data: rd1, last: (rem_q == CNT_W'(1))};
        wr1        = '{addr: cur_q + ADDR_W'(1), data: rd2, last: (rem_q == CNT_W'(2))};

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d      = first_addr;
                    rem_d      = CNT_W'(span) + CNT_W'(1);
                    checksum_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                // A lone trailing register still drives ra2, but rd2 is not buffered.
                push0 = 1'b1;
                if (rem_q >= CNT_W'(2)) begin
                    push1 = 1'b1;
                    cur_d = cur_q + ADDR_W'(2);
                    rem_d = rem_q - CNT_W'(2);
                end else begin
                    cur_d = cur_q + ADDR_W'(1);
                    rem_d = '0;
                end
                state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && (buf_count == 2'd1)) begin
                    state_d = (rem_q != '0) ? FETCH : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            checksum_d = checksum_q ^ head.data;
        end

        ra1_d  = (state_d == FETCH) ? cur_d : '0;
        ra2_d  = (state_d == FETCH) ? (cur_d + ADDR_W'(1)) : '0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            rem_q      <= '0;
            ra1_q      <= '0;
            ra2_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            ra1_q      <= ra1_d;
            ra2_q      <= ra2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            checksum_q <= checksum_d;
        end
    end

    assign ra1       = ra1_q;
    assign ra2       = ra2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign checksum  = checksum_q;
    assign out_valid = buf_valid;
    assign out_addr  = head.addr;
    assign out_data  = head.data;
    assign out_last  = head.last;

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side sequencer for the 32x32 register file.
- On a start pulse, walks a contiguous, wrapping address range using both read ports (ra1, ra2), two registers per fetch.
- Streams each register's address and data out over a valid/ready interface.
- Keeps a running XOR checksum of all emitted words, for debug dump and self-check of register contents.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NREGS, 32, number of registers (2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin dump; sampled only in IDLE
- first_addr  in  ADDR_W  first register of range; captured on accepted start
- last_addr  in  ADDR_W  last register of range; captured on accepted start
- ra1  out  ADDR_W  regfile read address 1
- ra2  out  ADDR_W  regfile read address 2
- rd1  in  DATA_W  regfile read data 1 (combinational from ra1)
- rd2  in  DATA_W  regfile read data 2 (combinational from ra2)
- out_valid  out  1  stream word valid
- out_ready  in  1  sink accepts word
- out_addr  out  ADDR_W  address of streamed word
- out_data  out  DATA_W  register contents
- out_last  out  1  final word of dump
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after final handshake
- checksum  out  DATA_W  XOR of all words handshaken in current/last dump

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; buffer emptied.
  - ra1 = ra2 = 0; out_valid = out_last = busy = done = 0; out_addr = 0; out_data = 0; checksum = 0.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - ra1 = ra2 = 0.
  - On start=1: capture cur = first_addr and remaining = ((last_addr - first_addr) mod NREGS) + 1 (range 1..32); clear checksum; go to FETCH.
- FETCH (one cycle):
  - Drive ra1 = cur, ra2 = (cur+1) mod NREGS.
  - At the clock edge, write {cur, rd1} into the 2-entry output buffer, plus {cur+1, rd2} only if remaining >= 2.
  - Then advance cur by 2 (or 1), decrement remaining accordingly, and go to DRAIN.
- DRAIN:
  - Present the buffer head on out_*. Pop on out_valid && out_ready.
  - When the buffer becomes empty: go to FETCH if remaining > 0, else go to DONE.
- DONE (one cycle): done = 1, then go to IDLE.
- Latency: start at edge N -> FETCH during cycle N+1 -> out_valid = 1 from cycle N+2.
  - Zero backpressure: 3 cycles per register pair.
- Wrap-around: address arithmetic is mod NREGS (31 -> 0).
  - first_addr > last_addr wraps.
  - first_addr == last_addr gives exactly 1 word.
  - first = 0, last = 31 gives 32 words.
- Single or odd trailing register: ra2 is still driven to cur+1, but rd2 is discarded.
- Handshake rules:
  - While out_valid && !out_ready, out_data, out_addr and out_last are held stable.
  - out_valid never drops without a handshake.
- out_last = 1 only on the final word, asserted together with out_valid.
- checksum ^= out_data on every handshake; it holds after done until the next accepted start.
- busy = 1 in FETCH, DRAIN and DONE.
- start while busy is ignored; first_addr/last_addr changes while busy have no effect.
- Register 0 is not special-cased: whatever rd1/rd2 returns is streamed.
- Reset mid-dump: immediate abort to reset values, no done pulse.

Decomposition:
- Package regfile_pkg:
  - Constants DATA_W, ADDR_W, NREGS.
  - typedef rf_state_t {IDLE, FETCH, DRAIN, DONE}.
  - typedef rf_word_t struct {addr, data, last}.
- Sub-module rf_out_buf:
  - 2-entry FIFO of rf_word_t.
  - Ports: push0/push1 write, valid/ready pop.
  - count output; async active-low reset.

Test Plan:
- Preload r[i]=i, range 1..5, out_ready=1 -> words (1,1),(2,2),(3,3),(4,4),(5,5); out_last only on addr 5; checksum=0x1; done one cycle after last handshake.
- Preload r[i]=i, first=30, last=1 -> addrs 30,31,0,1 with data 30,31,0,1; checksum=0x0; ra1 sequence 30 then 0.
- first=last=7, r[7]=0xDEADBEEF -> single word addr 7 with out_last=1; ra2=8 driven during FETCH; exactly one handshake.
- Full range 0..31, out_ready held low 5 cycles after first out_valid -> out_data/out_addr stable throughout; all 32 words then arrive in order with no loss or duplication.
- start pulsed again mid-dump with a different range -> ignored; original sequence completes unchanged.
- rst_n low during DRAIN -> all outputs at reset values asynchronously; no done pulse; a new start after release runs the dump from scratch.
